// File: rtl/pmod_keypad_if.sv
// Decoded-key output bundle of the keypad scanner, consumed by the display/entry logic.
interface pmod_keypad_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic [7:0] value;

  modport master (output key_code, output key_valid, output key_down, output value);
  modport slave  (input  key_code, input  key_valid, input  key_down, input  value);
endinterface

// File: rtl/pmod_keypad.sv
// 4x4 PMOD keypad scanner: column drive, row synchronizer, per-scan
// classification, scan-level debounce and two-digit key history.
module pmod_keypad #(
  parameter int unsigned COL_PERIOD     = 4096,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic         clk,
  input  logic         resetn,
  output logic [3:0]   pmod_col,
  input  logic [3:0]   pmod_row,
  pmod_keypad_if.master key
);

  localparam int unsigned       CNT_W    = (COL_PERIOD > 1) ? $clog2(COL_PERIOD) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(COL_PERIOD - 1);
  localparam logic [3:0]        DEB_MAX  = 4'(DEBOUNCE_SCANS);

  // Encoding doubles as the saturated closed-key count (0, 1, 2+).
  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_kind_e;

  logic [3:0]       row_s1_q, row_s2_q;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [3:0]       acc_code_q, acc_code_d;
  scan_kind_e       prev_kind_q, prev_kind_d;
  logic [3:0]       prev_code_q, prev_code_d;
  scan_kind_e       deb_kind_q, deb_kind_d;
  logic [3:0]       deb_code_q, deb_code_d;
  logic [3:0]       stab_q, stab_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic [7:0]       value_q, value_d;

  logic [3:0]       closed;
  logic [2:0]       col_hits, tot;
  logic [1:0]       tot_sat, hit_row;
  logic [3:0]       code_nxt;
  scan_kind_e       res_kind;
  logic [3:0]       res_code;

  function automatic logic [3:0] key_map(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'h1;  4'b00_01: k = 4'h2;  4'b00_10: k = 4'h3;  4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;  4'b01_01: k = 4'h5;  4'b01_10: k = 4'h6;  4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;  4'b10_01: k = 4'h8;  4'b10_10: k = 4'h9;  4'b10_11: k = 4'hC;
      4'b11_00: k = 4'h0;  4'b11_01: k = 4'hF;  4'b11_10: k = 4'hE;  default:  k = 4'hD;
    endcase
    return k;
  endfunction

  assign pmod_col       = ~(4'b0001 << col_idx_q);
  assign key.key_code   = key_code_q;
  assign key.key_valid  = key_valid_q;
  assign key.key_down   = (deb_kind_q == SCAN_SINGLE);
  assign key.value      = value_q;

  // Register all scan, debounce and output state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      row_s1_q    <= '1;
      row_s2_q    <= '1;
      col_idx_q   <= '0;
      per_cnt_q   <= '0;
      acc_cnt_q   <= '0;
      acc_code_q  <= '0;
      prev_kind_q <= SCAN_NONE;
      prev_code_q <= '0;
      deb_kind_q  <= SCAN_NONE;
      deb_code_q  <= '0;
      stab_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      value_q     <= '0;
    end else begin
      row_s1_q    <= pmod_row;
      row_s2_q    <= row_s1_q;
      col_idx_q   <= col_idx_d;
      per_cnt_q   <= per_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      prev_kind_q <= prev_kind_d;
      prev_code_q <= prev_code_d;
      deb_kind_q  <= deb_kind_d;
      deb_code_q  <= deb_code_d;
      stab_q      <= stab_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      value_q     <= value_d;
    end
  end

  // Column timing, scan accumulation, debounce and press acceptance.
  always_comb begin
    col_idx_d   = col_idx_q;
    per_cnt_d   = per_cnt_q + CNT_W'(1);
    acc_cnt_d   = acc_cnt_q;
    acc_code_d  = acc_code_q;
    prev_kind_d = prev_kind_q;
    prev_code_d = prev_code_q;
    deb_kind_d  = deb_kind_q;
    deb_code_d  = deb_code_q;
    stab_d      = stab_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    value_d     = value_q;

    closed   = ~row_s2_q;
    col_hits = {2'b00, closed[0]} + {2'b00, closed[1]} + {2'b00, closed[2]} + {2'b00, closed[3]};
    hit_row  = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (closed[r]) hit_row = 2'(r);
    end
    tot      = {1'b0, acc_cnt_q} + col_hits;
    tot_sat  = (tot >= 3'd2) ? 2'd2 : tot[1:0];
    code_nxt = (col_hits != 3'd0) ? key_map(col_idx_q, hit_row) : acc_code_q;
    res_kind = scan_kind_e'(tot_sat);
    res_code = (res_kind == SCAN_SINGLE) ? code_nxt : 4'h0;

    if (per_cnt_q == CNT_LAST) begin
      per_cnt_d = '0;
      col_idx_d = col_idx_q + 2'd1;
      if (col_idx_q != 2'd3) begin
        acc_cnt_d  = tot_sat;
        acc_code_d = code_nxt;
      end else begin
        // Final column of the scan: the result is formed from the live
        // column sample so classification adds no extra clock of latency.
        acc_cnt_d   = '0;
        acc_code_d  = '0;
        prev_kind_d = res_kind;
        prev_code_d = res_code;
        if (res_kind == prev_kind_q && res_code == prev_code_q)
          stab_d = (stab_q >= DEB_MAX) ? DEB_MAX : stab_q + 4'd1;
        else
          stab_d = 4'd1;
        if (stab_d == DEB_MAX && (res_kind != deb_kind_q || res_code != deb_code_q)) begin
          deb_kind_d = res_kind;
          deb_code_d = res_code;
          if (deb_kind_q == SCAN_NONE && res_kind == SCAN_SINGLE) begin
            key_valid_d = 1'b1;
            key_code_d  = res_code;
            value_d     = {value_q[3:0], res_code};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pmod_keypad.sv
// Directed bench for pmod_keypad with a behavioural 4x4 key matrix.
module tb_pmod_keypad;
  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  pmod_col;
  logic [3:0]  pmod_row;
  logic [15:0] pressed;   // index = col*4 + row
  int          total = 0;
  int          bad = 0;
  int          strobes = 0;
  int          base;
  int          n;

  pmod_keypad_if kif ();

  pmod_keypad #(.COL_PERIOD(8), .DEBOUNCE_SCANS(3)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .pmod_col (pmod_col),
    .pmod_row (pmod_row),
    .key      (kif)
  );

  always #5 clk = ~clk;

  // Key matrix: a closed key pulls its row low while its column is driven low.
  always_comb begin
    pmod_row = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4 + r] && !pmod_col[c]) pmod_row[r] = 1'b0;
  end

  always @(posedge clk) if (kif.key_valid === 1'b1) strobes <= strobes + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_valid(input int limit, output int cnt);
    cnt = 0;
    while (kif.key_valid !== 1'b1 && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    resetn  = 1'b0;
    pressed = '0;
    pressed[5] = 1'b1;                     // key 5 (c1,r1)
    repeat (5) begin
      tick(1);
      check("rst_col", pmod_col, 4'hE);
      check("rst_value", kif.value, 8'h00);
      check("rst_valid", kif.key_valid, 1'b0);
    end
    resetn = 1'b1;
    tick(7);
    check("col0_hold", pmod_col, 4'hE);
    tick(1);
    check("col_step", pmod_col, 4'hD);

    // single press, held from scan start
    base = strobes;
    wait_valid(200, n);
    check("lat_single", 8 + n, 96);
    check("code_5", kif.key_code, 4'h5);
    check("value_05", kif.value, 8'h05);
    tick(1);
    check("valid_1cyc", kif.key_valid, 1'b0);
    tick(103);
    check("one_strobe_5", strobes - base, 1);
    check("down_5", kif.key_down, 1'b1);
    check("value_05_hold", kif.value, 8'h05);
    pressed = '0;
    tick(150);
    check("up_5", kif.key_down, 1'b0);

    // two-digit entry A then 3
    base = strobes;
    pressed[12] = 1'b1; tick(150);
    check("value_5A", kif.value, 8'h5A);
    pressed = '0;       tick(150);
    pressed[8]  = 1'b1; tick(150);
    pressed = '0;       tick(150);
    check("two_strobes", strobes - base, 2);
    check("value_A3", kif.value, 8'hA3);
    check("code_3", kif.key_code, 4'h3);

    // bouncing key 9
    base = strobes;
    repeat (5) begin
      pressed[10] = 1'b1; tick(10);
      pressed[10] = 1'b0; tick(10);
    end
    check("bounce_quiet", strobes - base, 0);
    pressed[10] = 1'b1; tick(150);
    check("bounce_strobe", strobes - base, 1);
    check("code_9", kif.key_code, 4'h9);
    check("value_39", kif.value, 8'h39);
    pressed = '0; tick(150);

    // multi-key: 1 and 2 together
    base = strobes;
    pressed[0] = 1'b1; pressed[4] = 1'b1; tick(200);
    check("multi_quiet", strobes - base, 0);
    check("multi_down", kif.key_down, 1'b0);
    pressed[4] = 1'b0; tick(200);
    check("multi_to_single_quiet", strobes - base, 0);
    check("multi_to_single_down", kif.key_down, 1'b1);
    pressed = '0; tick(150);
    check("multi_release_down", kif.key_down, 1'b0);
    pressed[0] = 1'b1; tick(200);
    check("press1_strobe", strobes - base, 1);
    check("code_1", kif.key_code, 4'h1);
    check("value_91", kif.value, 8'h91);
    pressed = '0; tick(150);

    // reset during the strobe of key E
    pressed[11] = 1'b1;
    wait_valid(300, n);
    check("e_valid_seen", kif.key_valid, 1'b1);
    check("e_value_pre", kif.value, 8'h1E);
    resetn = 1'b0;
    tick(1);
    check("rst_mid_valid", kif.key_valid, 1'b0);
    check("rst_mid_value", kif.value, 8'h00);
    check("rst_mid_code", kif.key_code, 4'h0);
    tick(1);
    resetn = 1'b1;
    wait_valid(200, n);
    check("lat_after_rst", n, 96);
    check("value_0E", kif.value, 8'h0E);
    check("code_E", kif.key_code, 4'hE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pmod_keypad.md
PMOD_KEYPAD -- requirements
Module: pmod_keypad

Interface
REQ-001 SHALL have parameter COL_PERIOD, default 4096, meaning clocks each column is driven before its rows are sampled (legal range 8..65536).
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, meaning consecutive identical full-scan results required to accept a change (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port pmod_col, output, 4 bits: keypad column drive, active-low one-hot.
REQ-006 SHALL have port pmod_row, input, 4 bits: keypad row sense, asynchronous, active-low (external pull-ups).
REQ-007 SHALL have port key_code, output, 4 bits: hex code of the last accepted key.
REQ-008 SHALL have port key_valid, output, 1 bit: one-cycle strobe on each accepted press.
REQ-009 SHALL have port key_down, output, 1 bit: high while the debounced state is a single pressed key.
REQ-010 SHALL have port value, output, 8 bits: the last two accepted keys, newest in [3:0]; width-compatible with the two-digit hex display driver.

Function
REQ-011 SHALL pass pmod_row through a 2-flop synchronizer before any use.
REQ-012 SHALL drive column index c (0..3) as pmod_col with bit c low and all others high, for exactly COL_PERIOD clocks, then advance c with wrap 3->0.
REQ-013 SHALL sample the synchronized rows on the last clock of each column period (period counter == COL_PERIOD-1), recording bit r low as key (c,r) closed.
REQ-014 SHALL classify each full scan (columns 0..3) as NONE (no key closed), SINGLE(code) (exactly one key closed), or MULTI (two or more keys closed).
REQ-015 SHALL map (c,r) to code per row r: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: 0,F,E,D (entries listed for c=0..3).
REQ-016 SHALL keep a stability counter: +1 (saturating at DEBOUNCE_SCANS) when the scan result equals the previous scan result, else reload to 1.
REQ-017 SHALL update the debounced state to the current scan result when the stability counter reaches DEBOUNCE_SCANS and the result differs from the debounced state.
REQ-018 SHALL, only on a debounced transition NONE -> SINGLE(k), on the clock after the final column-3 sample: pulse key_valid for one cycle, set key_code=k, set value={value[3:0],k}.
REQ-019 SHALL NOT pulse key_valid on transitions into NONE or MULTI, nor on MULTI->SINGLE or SINGLE(a)->SINGLE(b); a new press is accepted only after a debounced NONE.
REQ-020 SHALL drive key_down=1 exactly while the debounced state is SINGLE; key_code and value hold between accepted presses.
REQ-021 SHALL give press-to-strobe latency: DEBOUNCE_SCANS full scans (4*COL_PERIOD clocks each) after the first scan that fully sees the key, plus 1 clock.
REQ-022 SHALL be free-running: no handshake; key_valid is not back-pressured and a consumer missing it loses only the strobe (value still updated).

Reset
REQ-023 SHALL, while resetn=0 at a clock edge: pmod_col=4'b1110, column index 0, period counter 0, synchronizer flops 4'b1111, scan accumulators cleared, previous result and debounced state NONE, stability counter 0, key_code=0, key_valid=0, key_down=0, value=8'h00.
REQ-024 SHALL, on reset asserted mid-scan or mid-strobe, abandon the scan and drop key_valid on the next edge; first post-reset scan starts at column 0 with a full COL_PERIOD.

Verification (bench uses COL_PERIOD=8, DEBOUNCE_SCANS=3; full scan = 32 clocks)
REQ-025 SHALL check reset: hold resetn=0 for 5 clocks with key 5 held -> pmod_col=4'b1110, value=8'h00, key_valid=0 throughout; pmod_col steps to 4'b1101 after 8 clocks of resetn=1.
REQ-026 SHALL check single press: press key (c=1,r=1) before a scan start, hold 200 clocks -> exactly one key_valid pulse, key_code=4'h5, value=8'h05, key_down=1, strobe 1 clock after the third full scan's column-3 sample.
REQ-027 SHALL check two-digit entry: press/release A, then press/release 3, each held and released for >=150 clocks -> two strobes, value=8'hA3.
REQ-028 SHALL check bounce: toggle row of key 9 every 10 clocks for 100 clocks then hold 150 clocks -> one strobe, key_code=4'h9; no strobe during toggling.
REQ-029 SHALL check multi-key: hold keys 1 and 2 together 200 clocks -> no strobe, key_down=0; release 2 with 1 held -> still no strobe; release all, press 1 -> one strobe with code 4'h1.
REQ-030 SHALL check reset mid-operation: assert resetn=0 on the key_valid cycle of a key E press -> key_valid=0 next edge, value=8'h00; key E still held after release of reset -> new strobe after 3 scans, value=8'h0E.
